// File: rtl/trans_sid_client.sv
// Controller-side client of the transfer-SID allocator: requests SIDs, tracks
// ownership and termination, and releases SIDs on software free commands.
module trans_sid_client #(
    parameter int NB_TRANSFERS    = 4,
    parameter int TRANS_SID_WIDTH = 2,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_req_i,
    output logic                       alloc_busy_o,
    output logic                       alloc_rsp_o,
    output logic [TRANS_SID_WIDTH-1:0] alloc_sid_o,
    output logic                       trans_req_o,
    input  logic                       trans_gnt_i,
    input  logic [TRANS_SID_WIDTH-1:0] trans_sid_i,
    output logic [NB_TRANSFERS-1:0]    trans_clr_o,
    input  logic [NB_TRANSFERS-1:0]    term_sig_i,
    input  logic                       free_req_i,
    input  logic [TRANS_SID_WIDTH-1:0] free_sid_i,
    output logic                       free_ack_o,
    output logic                       free_err_o,
    output logic [NB_TRANSFERS-1:0]    owned_o,
    output logic [NB_TRANSFERS-1:0]    done_o,
    output logic                       done_evt_o,
    output logic [CNT_WIDTH-1:0]       nb_owned_o
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t                     state_q, state_d;
    logic [TRANS_SID_WIDTH-1:0] sid_q;
    logic [NB_TRANSFERS-1:0]    owned_q, owned_d;
    logic [NB_TRANSFERS-1:0]    done_q, done_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       grant, sid_ok, free_ok;
    logic [31:0]                free_sid_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (alloc_req_i) state_d = REQ;
            REQ:     if (trans_gnt_i) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant        = (state_q == REQ) && trans_gnt_i;
    assign free_sid_ext = 32'(free_sid_i);
    assign sid_ok       = free_sid_ext < NB_TRANSFERS;
    // A term arriving with the free counts as done, so the two can coincide.
    assign free_ok      = free_req_i && sid_ok && owned_q[free_sid_i] &&
                          (done_q[free_sid_i] || term_sig_i[free_sid_i]);

    always_comb begin
        owned_d = owned_q;
        done_d  = done_q | (term_sig_i & owned_q);
        if (grant) begin
            owned_d[trans_sid_i] = 1'b1;
            done_d[trans_sid_i]  = 1'b0;
        end
        if (free_ok) begin
            owned_d[free_sid_i] = 1'b0;
            done_d[free_sid_i]  = 1'b0;
        end
        cnt_d = cnt_q + CNT_WIDTH'(grant) - CNT_WIDTH'(free_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sid_q       <= '0;
            owned_q     <= '0;
            done_q      <= '0;
            cnt_q       <= '0;
            done_evt_o  <= 1'b0;
            free_ack_o  <= 1'b0;
            free_err_o  <= 1'b0;
            trans_clr_o <= '0;
        end else begin
            if (grant) sid_q <= trans_sid_i;
            owned_q     <= owned_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            done_evt_o  <= |(term_sig_i & owned_q & ~done_q);
            free_ack_o  <= free_ok;
            free_err_o  <= free_req_i && !free_ok;
            trans_clr_o <= free_ok ? (NB_TRANSFERS'(1) << free_sid_i) : '0;
        end
    end

    assign trans_req_o  = (state_q == REQ);
    assign alloc_busy_o = (state_q != IDLE);
    assign alloc_rsp_o  = (state_q == RSP);
    assign alloc_sid_o  = (state_q == RSP) ? sid_q : '0;
    assign owned_o      = owned_q;
    assign done_o       = done_q;
    assign nb_owned_o   = cnt_q;

    // The allocator must never hand out a SID this controller already holds.
    a_grant_unowned: assert property (@(posedge clk_i) disable iff (rst_i)
        grant |-> !owned_q[trans_sid_i]);

endmodule

// File: tb/tb_trans_sid_client.sv
// Directed self-checking bench for trans_sid_client.
module tb_trans_sid_client;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       alloc_req_i;
    logic       alloc_busy_o;
    logic       alloc_rsp_o;
    logic [1:0] alloc_sid_o;
    logic       trans_req_o;
    logic       trans_gnt_i;
    logic [1:0] trans_sid_i;
    logic [3:0] trans_clr_o;
    logic [3:0] term_sig_i;
    logic       free_req_i;
    logic [1:0] free_sid_i;
    logic       free_ack_o;
    logic       free_err_o;
    logic [3:0] owned_o;
    logic [3:0] done_o;
    logic       done_evt_o;
    logic [2:0] nb_owned_o;

    int checks = 0;
    int errors = 0;
    int rsp_count;

    trans_sid_client dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_req_i (alloc_req_i),
        .alloc_busy_o(alloc_busy_o),
        .alloc_rsp_o (alloc_rsp_o),
        .alloc_sid_o (alloc_sid_o),
        .trans_req_o (trans_req_o),
        .trans_gnt_i (trans_gnt_i),
        .trans_sid_i (trans_sid_i),
        .trans_clr_o (trans_clr_o),
        .term_sig_i  (term_sig_i),
        .free_req_i  (free_req_i),
        .free_sid_i  (free_sid_i),
        .free_ack_o  (free_ack_o),
        .free_err_o  (free_err_o),
        .owned_o     (owned_o),
        .done_o      (done_o),
        .done_evt_o  (done_evt_o),
        .nb_owned_o  (nb_owned_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full allocation of a given SID: request, grant, response, back to IDLE.
    task automatic do_alloc(input logic [1:0] sid);
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        check("alloc_req_up", 32'(trans_req_o), 1);
        trans_gnt_i = 1'b1;
        trans_sid_i = sid;
        tick();
        trans_gnt_i = 1'b0;
        check("alloc_rsp", 32'(alloc_rsp_o), 1);
        check("alloc_sid", 32'(alloc_sid_o), 32'(sid));
        tick();
        check("alloc_idle", 32'(alloc_busy_o), 0);
    endtask

    initial begin
        rst_i       = 1'b1;
        alloc_req_i = 1'b0;
        trans_gnt_i = 1'b0;
        trans_sid_i = 2'd0;
        term_sig_i  = 4'b0;
        free_req_i  = 1'b0;
        free_sid_i  = 2'd0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_busy",  32'(alloc_busy_o), 0);
        check("rst_req",   32'(trans_req_o), 0);
        check("rst_rsp",   32'(alloc_rsp_o), 0);
        check("rst_owned", 32'(owned_o), 0);
        check("rst_nb",    32'(nb_owned_o), 0);
        check("rst_clr",   32'(trans_clr_o), 0);

        // 1: request pulse, grant of SID 2 three cycles later
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t1_req", 32'(trans_req_o), 1);
            check("t1_busy", 32'(alloc_busy_o), 1);
            check("t1_norsp", 32'(alloc_rsp_o), 0);
            if (i == 2) begin
                trans_gnt_i = 1'b1;
                trans_sid_i = 2'd2;
            end
            tick();
        end
        trans_gnt_i = 1'b0;
        check("t1_rsp",    32'(alloc_rsp_o), 1);
        check("t1_sid",    32'(alloc_sid_o), 2);
        check("t1_req_dn", 32'(trans_req_o), 0);
        check("t1_owned",  32'(owned_o), 4'b0100);
        check("t1_nb",     32'(nb_owned_o), 1);
        tick();
        check("t1_rsp_one", 32'(alloc_rsp_o), 0);
        check("t1_sid_zero", 32'(alloc_sid_o), 0);
        check("t1_idle",    32'(alloc_busy_o), 0);

        // free of an owned but unterminated SID is rejected
        free_req_i = 1'b1;
        free_sid_i = 2'd2;
        tick();
        free_req_i = 1'b0;
        check("t1_early_err", 32'(free_err_o), 1);
        check("t1_early_ack", 32'(free_ack_o), 0);
        check("t1_early_own", 32'(owned_o), 4'b0100);

        // 2: termination of SID 2, then a repeated pulse
        term_sig_i = 4'b0100;
        tick();
        term_sig_i = 4'b0;
        check("t2_done", 32'(done_o), 4'b0100);
        check("t2_evt",  32'(done_evt_o), 1);
        tick();
        check("t2_evt_one", 32'(done_evt_o), 0);
        term_sig_i = 4'b0100;
        tick();
        term_sig_i = 4'b0;
        check("t2_evt_again", 32'(done_evt_o), 0);
        check("t2_done_hold", 32'(done_o), 4'b0100);
        term_sig_i = 4'b0010;   // unowned SID
        tick();
        term_sig_i = 4'b0;
        check("t2_unowned_done", 32'(done_o), 4'b0100);
        check("t2_unowned_evt",  32'(done_evt_o), 0);

        // 3: accepted free of SID 2, rejected free of SID 1
        free_req_i = 1'b1;
        free_sid_i = 2'd2;
        tick();
        free_sid_i = 2'd1;
        check("t3_ack",   32'(free_ack_o), 1);
        check("t3_err",   32'(free_err_o), 0);
        check("t3_clr",   32'(trans_clr_o), 4'b0100);
        check("t3_owned", 32'(owned_o), 0);
        check("t3_done",  32'(done_o), 0);
        check("t3_nb",    32'(nb_owned_o), 0);
        tick();
        free_req_i = 1'b0;
        check("t3_err1", 32'(free_err_o), 1);
        check("t3_ack1", 32'(free_ack_o), 0);
        check("t3_clr1", 32'(trans_clr_o), 0);
        tick();
        check("t3_err_pulse", 32'(free_err_o), 0);

        // back-to-back frees of SIDs 1 and 3
        do_alloc(2'd1);
        do_alloc(2'd3);
        check("t3_nb2", 32'(nb_owned_o), 2);
        term_sig_i = 4'b1010;
        tick();
        term_sig_i = 4'b0;
        free_req_i = 1'b1;
        free_sid_i = 2'd1;
        tick();
        free_sid_i = 2'd3;
        check("t3_b2b_clr1", 32'(trans_clr_o), 4'b0010);
        tick();
        free_req_i = 1'b0;
        check("t3_b2b_ack3", 32'(free_ack_o), 1);
        check("t3_b2b_clr3", 32'(trans_clr_o), 4'b1000);
        check("t3_b2b_nb",   32'(nb_owned_o), 0);

        // 4: term and free of SID 3 in the same cycle
        do_alloc(2'd3);
        term_sig_i = 4'b1000;
        free_req_i = 1'b1;
        free_sid_i = 2'd3;
        tick();
        term_sig_i = 4'b0;
        free_req_i = 1'b0;
        check("t4_ack",   32'(free_ack_o), 1);
        check("t4_clr",   32'(trans_clr_o), 4'b1000);
        check("t4_done",  32'(done_o), 0);
        check("t4_owned", 32'(owned_o), 0);

        // 5: all SIDs owned, grant withheld for 20 cycles
        for (int s = 0; s < 4; s++) do_alloc(2'(s));
        check("t5_nb4", 32'(nb_owned_o), 4);
        check("t5_own4", 32'(owned_o), 4'b1111);
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            alloc_req_i = (i == 7);
            check("t5_req_hold", 32'(trans_req_o), 1);
            check("t5_busy_hold", 32'(alloc_busy_o), 1);
            tick();
        end
        alloc_req_i = 1'b0;
        term_sig_i = 4'b0001;
        free_req_i = 1'b1;
        free_sid_i = 2'd0;
        tick();
        term_sig_i = 4'b0;
        free_req_i = 1'b0;
        check("t5_free0", 32'(free_ack_o), 1);
        check("t5_nb3",   32'(nb_owned_o), 3);
        // grant SID 0 while freeing SID 1 in the same cycle
        trans_gnt_i = 1'b1;
        trans_sid_i = 2'd0;
        term_sig_i  = 4'b0010;
        free_req_i  = 1'b1;
        free_sid_i  = 2'd1;
        tick();
        trans_gnt_i = 1'b0;
        term_sig_i  = 4'b0;
        free_req_i  = 1'b0;
        check("t5_both_ack", 32'(free_ack_o), 1);
        check("t5_both_own", 32'(owned_o), 4'b1101);
        check("t5_both_nb",  32'(nb_owned_o), 3);
        rsp_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (alloc_rsp_o) rsp_count++;
            tick();
        end
        check("t5_one_rsp", 32'(rsp_count), 1);
        check("t5_dropped", 32'(trans_req_o), 0);

        // 6: reset while in REQ with two SIDs owned
        term_sig_i = 4'b1000;
        free_req_i = 1'b1;
        free_sid_i = 2'd3;
        tick();
        term_sig_i = 4'b0;
        free_req_i = 1'b0;
        check("t6_nb2", 32'(nb_owned_o), 2);
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        check("t6_in_req", 32'(trans_req_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_req",   32'(trans_req_o), 0);
        check("t6_busy",  32'(alloc_busy_o), 0);
        check("t6_owned", 32'(owned_o), 0);
        check("t6_nb",    32'(nb_owned_o), 0);
        do_alloc(2'd1);
        check("t6_owned1", 32'(owned_o), 4'b0010);
        check("t6_nb1",    32'(nb_owned_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
